// File: rtl/dma_drain_arb.sv
// DMA drain stage: round-robin arbiter that pops one word per grant from four
// channel FIFOs and writes it to the system bus through a valid/ready port.
//
// state | meaning
// IDLE  | no channel active
// ARB   | scan from pointer for an active channel whose FIFO has data
// RD    | pop strobe to the granted FIFO
// CAP   | FIFO data valid; load bus address/data, raise bus_valid
// WR    | hold the request until bus_ready, then advance the channel
module dma_drain_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      start,
  input  logic [4*AW-1:0] dst_addr,
  input  logic [4*LW-1:0] len,
  input  logic [3:0]      fifo_empty,
  input  logic [4*DW-1:0] fifo_rdata,
  output logic [3:0]      fifo_rd,
  output logic            bus_valid,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_ready,
  output logic [3:0]      done,
  output logic [3:0]      busy
);

  typedef enum logic [2:0] {IDLE, ARB, RD, CAP, WR} state_t;

  state_t        state;
  logic [3:0]    active;
  logic [AW-1:0] cur_addr [4];
  logic [LW-1:0] remain [4];
  logic [1:0]    ptr;
  logic [1:0]    grant;
  logic [3:0]    eligible;
  logic          found;
  logic [1:0]    pick;

  assign busy = active;

  // Scan downward so the last hit kept is the nearest to the pointer.
  always_comb begin
    eligible = active & ~fifo_empty;
    found    = 1'b0;
    pick     = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[ptr + 2'(i)]) begin
        found = 1'b1;
        pick  = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active    <= '0;
      ptr       <= '0;
      grant     <= '0;
      fifo_rd   <= '0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      done      <= '0;
      for (int n = 0; n < 4; n++) begin
        cur_addr[n] <= '0;
        remain[n]   <= '0;
      end
    end else begin
      done    <= '0;
      fifo_rd <= '0;

      for (int n = 0; n < 4; n++) begin
        if (start[n] && !active[n]) begin
          if (len[n*LW +: LW] != '0) begin
            active[n]   <= 1'b1;
            cur_addr[n] <= dst_addr[n*AW +: AW];
            remain[n]   <= len[n*LW +: LW];
          end else begin
            done[n] <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (|active) state <= ARB;
        end
        ARB: begin
          if (found) begin
            grant   <= pick;
            fifo_rd <= 4'b0001 << pick;
            state   <= RD;
          end else if (!(|active)) begin
            state <= IDLE;
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          bus_wdata <= fifo_rdata[grant*DW +: DW];
          bus_addr  <= cur_addr[grant];
          bus_valid <= 1'b1;
          state     <= WR;
        end
        WR: begin
          if (bus_ready) begin
            bus_valid       <= 1'b0;
            cur_addr[grant] <= cur_addr[grant] + AW'(4);
            remain[grant]   <= remain[grant] - LW'(1);
            ptr             <= grant + 2'd1;
            if (remain[grant] == LW'(1)) begin
              active[grant] <= 1'b0;
              done[grant]   <= 1'b1;
            end
            state <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_drain_arb.sv
// Directed bench for dma_drain_arb: table of single-channel transfers plus
// hand-written round-robin, backpressure, stall, edge-start and reset sequences.
module tb_dma_drain_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   start = '0;
  logic [127:0] dst_addr = '0;
  logic [63:0]  len = '0;
  logic [3:0]   fifo_empty;
  logic [127:0] fifo_rdata = '0;
  logic [3:0]   fifo_rd;
  logic         bus_valid;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ready = 1'b1;
  logic [3:0]   done;
  logic [3:0]   busy;

  int n_pass = 0;
  int n_total = 0;

  dma_drain_arb #(.AW(32), .DW(32), .LW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .len(len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle read latency
  logic [31:0] mem [4][32];
  int wp [4] = '{0, 0, 0, 0};
  int rp [4] = '{0, 0, 0, 0};
  int pop_cnt [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};
  int bad_pop = 0;
  int multi_pop = 0;
  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];
  int pop_q [$];

  always_comb begin
    for (int n = 0; n < 4; n++) fifo_empty[n] = (wp[n] == rp[n]);
  end

  always @(posedge clk) begin
    if ($countones(fifo_rd) > 1) multi_pop <= multi_pop + 1;
    for (int n = 0; n < 4; n++) begin
      if (fifo_rd[n]) begin
        if (wp[n] == rp[n]) bad_pop <= bad_pop + 1;
        fifo_rdata[n*32 +: 32] <= mem[n][rp[n] % 32];
        rp[n] <= rp[n] + 1;
        pop_cnt[n] <= pop_cnt[n] + 1;
        pop_q.push_back(n);
      end
      if (done[n]) done_cnt[n] <= done_cnt[n] + 1;
    end
    if (bus_valid && bus_ready) begin
      wr_a.push_back(bus_addr);
      wr_d.push_back(bus_wdata);
    end
  end

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
    logic [15:0] len;
    logic [31:0] d0, d1, d2;
    logic [31:0] a0, a1, a2;
  } vec_t;

  vec_t vec [4];

  function automatic vec_t mk(input logic [1:0] ch, input logic [31:0] addr,
                              input logic [15:0] l,
                              input logic [31:0] d0, d1, d2, a0, a1, a2);
    vec_t v;
    v.ch = ch; v.addr = addr; v.len = l;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    mem[ch][wp[ch] % 32] = d;
    wp[ch] = wp[ch] + 1;
  endtask

  task automatic start_ch(input int ch, input logic [31:0] a, input logic [15:0] l);
    @(negedge clk);
    dst_addr[ch*32 +: 32] = a;
    len[ch*16 +: 16] = l;
    start[ch] = 1'b1;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_done(input int ch, input int bound, input string name);
    bit seen = 0;
    for (int c = 0; c < bound; c++) begin
      if (done[ch]) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic wait_valid(input int bound, input string name);
    bit seen = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (bus_valid) begin seen = 1; break; end
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p0, d0c, t1, t3;
    logic [31:0] ea, ed;

    vec[0] = mk(2'd0, 32'h0000_1000, 16'd3, 32'hA, 32'hB, 32'hC,
                32'h0000_1000, 32'h0000_1004, 32'h0000_1008);
    vec[1] = mk(2'd2, 32'hFFFF_FFFC, 16'd2, 32'h11, 32'h22, 32'h0,
                32'hFFFF_FFFC, 32'h0000_0000, 32'h0);
    vec[2] = mk(2'd3, 32'h0000_0020, 16'd1, 32'h55, 32'h0, 32'h0,
                32'h0000_0020, 32'h0, 32'h0);
    vec[3] = mk(2'd1, 32'h8000_0000, 16'd2, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,
                32'h8000_0000, 32'h8000_0004, 32'h0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // table of single-channel transfers
    for (int i = 0; i < 4; i++) begin
      int ch;
      ch = int'(vec[i].ch);
      wr_a.delete(); wr_d.delete();
      p0 = pop_cnt[ch];
      d0c = done_cnt[ch];
      push(ch, vec[i].d0);
      if (vec[i].len > 1) push(ch, vec[i].d1);
      if (vec[i].len > 2) push(ch, vec[i].d2);
      start_ch(ch, vec[i].addr, vec[i].len);
      chk($sformatf("v%0d_busy_up", i), busy[ch], 1);
      wait_done(ch, 200, $sformatf("v%0d_done_wait", i));
      @(negedge clk);
      chk($sformatf("v%0d_nwr", i), wr_a.size(), vec[i].len);
      for (int k = 0; k < int'(vec[i].len) && k < wr_a.size(); k++) begin
        ea = (k == 0) ? vec[i].a0 : (k == 1) ? vec[i].a1 : vec[i].a2;
        ed = (k == 0) ? vec[i].d0 : (k == 1) ? vec[i].d1 : vec[i].d2;
        chk($sformatf("v%0d_addr%0d", i, k), wr_a[k], ea);
        chk($sformatf("v%0d_data%0d", i, k), wr_d[k], ed);
      end
      chk($sformatf("v%0d_pops", i), pop_cnt[ch] - p0, vec[i].len);
      chk($sformatf("v%0d_done_cnt", i), done_cnt[ch] - d0c, 1);
      chk($sformatf("v%0d_busy_down", i), busy[ch], 0);
    end

    // round-robin: pointer back at 0, ch1 and ch3 each two words
    do_reset();
    wr_a.delete(); wr_d.delete(); pop_q.delete();
    push(1, 32'h101); push(1, 32'h102);
    push(3, 32'h301); push(3, 32'h302);
    @(negedge clk);
    dst_addr[1*32 +: 32] = 32'h100; len[1*16 +: 16] = 16'd2;
    dst_addr[3*32 +: 32] = 32'h300; len[3*16 +: 16] = 16'd2;
    start = 4'b1010;
    @(negedge clk);
    start = '0;
    t1 = -1; t3 = -1;
    for (int c = 0; c < 200 && (t1 < 0 || t3 < 0); c++) begin
      if (done[1] && t1 < 0) t1 = c;
      if (done[3] && t3 < 0) t3 = c;
      @(negedge clk);
    end
    if (t1 < 0 || t3 < 0) timeout_fail("rr_done_wait");
    chk("rr_npop", pop_q.size(), 4);
    if (pop_q.size() == 4) begin
      chk("rr_g0", pop_q[0], 1);
      chk("rr_g1", pop_q[1], 3);
      chk("rr_g2", pop_q[2], 1);
      chk("rr_g3", pop_q[3], 3);
    end
    chk("rr_done_order", (t1 >= 0 && t1 < t3), 1);
    if (wr_a.size() == 4) begin
      chk("rr_a0", {wr_a[0], wr_d[0]}, {32'h100, 32'h101});
      chk("rr_a1", {wr_a[1], wr_d[1]}, {32'h300, 32'h301});
      chk("rr_a2", {wr_a[2], wr_d[2]}, {32'h104, 32'h102});
      chk("rr_a3", {wr_a[3], wr_d[3]}, {32'h304, 32'h302});
    end else chk("rr_nwr", wr_a.size(), 4);

    // backpressure
    wr_a.delete(); wr_d.delete();
    bus_ready = 1'b0;
    push(0, 32'h77);
    p0 = pop_cnt[0];
    start_ch(0, 32'h40, 16'd1);
    wait_valid(50, "bp_valid_wait");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), bus_valid, 1);
      chk($sformatf("bp_addr%0d", c), bus_addr, 32'h40);
      chk($sformatf("bp_data%0d", c), bus_wdata, 32'h77);
      chk($sformatf("bp_pop%0d", c), pop_cnt[0] - p0, 1);
      @(negedge clk);
    end
    chk("bp_nwr_held", wr_a.size(), 0);
    bus_ready = 1'b1;
    wait_done(0, 20, "bp_done_wait");
    chk("bp_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) chk("bp_write", {wr_a[0], wr_d[0]}, {32'h40, 32'h77});

    // empty-FIFO stall on ch2
    wr_a.delete(); wr_d.delete();
    p0 = pop_cnt[2];
    start_ch(2, 32'h300, 16'd2);
    repeat (10) @(negedge clk);
    chk("stall_pops", pop_cnt[2] - p0, 0);
    chk("stall_busy", busy[2], 1);
    chk("stall_valid", bus_valid, 0);
    push(2, 32'h99);
    repeat (15) @(negedge clk);
    chk("stall_nwr1", wr_a.size(), 1);
    if (wr_a.size() >= 1) chk("stall_w1", {wr_a[0], wr_d[0]}, {32'h300, 32'h99});
    chk("stall_busy_mid", busy[2], 1);
    push(2, 32'h9A);
    wait_done(2, 50, "stall_done_wait");
    @(negedge clk);
    chk("stall_nwr2", wr_a.size(), 2);
    if (wr_a.size() == 2) chk("stall_w2", {wr_a[1], wr_d[1]}, {32'h304, 32'h9A});

    // zero-length start
    d0c = done_cnt[1];
    start_ch(1, 32'h5000, 16'd0);
    chk("len0_done", done[1], 1);
    chk("len0_busy", busy[1], 0);
    @(negedge clk);
    chk("len0_done_off", done[1], 0);
    chk("len0_busy_after", busy[1], 0);
    chk("len0_done_cnt", done_cnt[1] - d0c, 1);

    // restart of an active channel is ignored
    wr_a.delete(); wr_d.delete();
    p0 = pop_cnt[2];
    d0c = done_cnt[2];
    start_ch(2, 32'h700, 16'd2);
    repeat (3) @(negedge clk);
    start_ch(2, 32'h900, 16'd5);
    repeat (3) @(negedge clk);
    push(2, 32'h31); push(2, 32'h32);
    wait_done(2, 100, "restart_done_wait");
    repeat (10) @(negedge clk);
    chk("restart_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      chk("restart_w0", {wr_a[0], wr_d[0]}, {32'h700, 32'h31});
      chk("restart_w1", {wr_a[1], wr_d[1]}, {32'h704, 32'h32});
    end
    chk("restart_pops", pop_cnt[2] - p0, 2);
    chk("restart_done_cnt", done_cnt[2] - d0c, 1);
    chk("restart_busy", busy[2], 0);

    // reset while a write is pending
    wr_a.delete(); wr_d.delete();
    bus_ready = 1'b0;
    push(0, 32'h61); push(0, 32'h62);
    d0c = done_cnt[0];
    start_ch(0, 32'h500, 16'd2);
    wait_valid(50, "mid_valid_wait");
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", bus_valid, 0);
    chk("mid_addr", bus_addr, 0);
    chk("mid_wdata", bus_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_fifo_rd", fifo_rd, 0);
    chk("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    bus_ready = 1'b1;
    chk("mid_done_cnt", done_cnt[0] - d0c, 0);
    start_ch(0, 32'h600, 16'd1);
    wait_done(0, 50, "mid_done_wait");
    @(negedge clk);
    chk("mid_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) chk("mid_w", {wr_a[0], wr_d[0]}, {32'h600, 32'h62});

    chk("no_pop_empty", bad_pop, 0);
    chk("onehot_pop", multi_pop, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_drain_arb.md
Name: dma_drain_arb

Overview:
- DMA drain stage directly downstream of the 4-FIFO channel block.
- Per channel, software programs a destination address and a word count and pulses start.
- The block round-robins across active channels. Per grant it pops one 32-bit word from that channel's FIFO and writes it to the system bus through a valid/ready write port.
- It pulses a per-channel done when the programmed count has been written.

Parameters:
- AW, 32, bus address width in bits.
- DW, 32, data width in bits; must equal the FIFO word width.
- LW, 16, width of the per-channel word-count register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  4  per-channel start pulse; bit n starts channel n.
- dst_addr  input  4*AW  per-channel start address; channel n occupies bits [n*AW +: AW].
- len  input  4*LW  per-channel word count; channel n occupies bits [n*LW +: LW].
- fifo_empty  input  4  empty flags from the channel FIFOs.
- fifo_rdata  input  4*DW  read data from the channel FIFOs; channel n occupies bits [n*DW +: DW].
- fifo_rd  output  4  one-cycle pop strobes to the channel FIFOs.
- bus_valid  output  1  write request valid.
- bus_addr  output  AW  write address.
- bus_wdata  output  DW  write data.
- bus_ready  input  1  bus accepts the write when bus_valid and bus_ready are both high at a rising edge.
- done  output  4  one-cycle completion pulse per channel.
- busy  output  4  channel n is active (started and not yet done).

Behaviour:
- Reset (rst low, asynchronous) clears all of the following:
  - all outputs go to 0;
  - the FSM goes to IDLE;
  - all channels go inactive;
  - the round-robin pointer goes to 0.
- Reset mid-transfer abandons that transfer. No done pulse is issued. FIFO contents are untouched.
- Per-channel registers: active, cur_addr[AW], remain[LW].
- On start[n] with channel n inactive and len_n != 0:
  - active_n is set;
  - cur_addr_n <= dst_addr_n;
  - remain_n <= len_n.
  - busy[n] rises the following cycle.
- start[n] while channel n is active is ignored.
- start[n] with len_n == 0: done[n] pulses the following cycle; the channel never becomes active.
- Eligibility: channel n is eligible when active_n and !fifo_empty[n].
- FSM states and transitions:
  - IDLE: go to ARB when any channel is active.
  - ARB: search starts at the pointer and scans n, n+1, … mod 4. The first eligible channel is registered as grant g, and the FSM goes to RD. With no eligible channel, stay in ARB; with no active channel, return to IDLE.
  - RD: fifo_rd[g] = 1 for exactly this cycle, then go to CAP. FIFO read latency is 1 cycle: data is valid in the cycle after the pop.
  - CAP: bus_wdata <= fifo_rdata[g]; bus_addr <= cur_addr_g; bus_valid <= 1; go to WR.
  - WR: hold bus_valid, bus_addr and bus_wdata stable until bus_ready is sampled high. On the handshake edge:
    - bus_valid <= 0;
    - cur_addr_g <= cur_addr_g + 4, with AW-bit wrap (0xFFFFFFFC + 4 = 0);
    - remain_g <= remain_g - 1;
    - pointer <= (g + 1) mod 4.
    - If remain_g was 1: clear active_g and pulse done[g] for one cycle, coincident with busy[g] falling.
    - Then go to ARB.
- One word per grant. Minimum 4 cycles per word (ARB, RD, CAP, WR with ready already high). Channels interleave word by word.
- At most one fifo_rd bit is high in any cycle. fifo_rd is never asserted to an empty FIFO.
- A start on a channel that is not the current grant proceeds normally during an ongoing transfer.
- A start on channel g during WR for its final word is ignored, because the channel is still active.
- bus_ready is ignored while bus_valid = 0.

Test Plan:
1. Single channel: ch0 addr 0x1000, len 3, FIFO preloaded with 0xA, 0xB, 0xC, bus_ready tied 1 -> bus writes (0x1000, 0xA), (0x1004, 0xB), (0x1008, 0xC); exactly 3 fifo_rd[0] pulses; done[0] pulses once on the third handshake; busy[0] then goes to 0.
2. Round-robin: ch1 and ch3 each with len 2, both FIFOs non-empty -> grant order 1, 3, 1, 3; done[1] pulses before done[3].
3. Backpressure: hold bus_ready low for 5 cycles during WR -> bus_valid, bus_addr and bus_wdata stay stable; no further fifo_rd; the write completes on the first ready cycle.
4. Empty stall: ch2 len 2 with its FIFO empty -> no fifo_rd, FSM stays in ARB; push one word -> one write; the next word is written only after a second push.
5. Edge starts: start with len 0 -> done pulse next cycle, busy stays 0; restart of an active channel -> ignored, count unchanged; addr 0xFFFFFFFC with len 2 -> writes to 0xFFFFFFFC, then 0x0.
6. Reset mid-WR: assert rst low with bus_valid = 1 -> all outputs go to 0 immediately, no done pulse; after release a new start on the same channel runs from its freshly loaded address.
